// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants for the scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}; the decimal point is added by the driver.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Full LEDOUT byte with every segment and the dp dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Bit positions inside LEDOUT = {dp,g,f,e,d,c,b,a}.
  localparam int SEG_BIT_DP = 7;
  localparam int SEG_BIT_G  = 6;
  localparam int SEG_BIT_F  = 5;
  localparam int SEG_BIT_E  = 4;
  localparam int SEG_BIT_D  = 3;
  localparam int SEG_BIT_C  = 2;
  localparam int SEG_BIT_B  = 1;
  localparam int SEG_BIT_A  = 0;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low {g..a} segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Plain lookup of the sixteen hex glyphs (lower-case b and d).
  always_comb begin
    seg = SEG_8;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: N-digit multiplexed seven-segment driver with prescaler,
// PWM brightness, per-digit decimal points and double-buffered value loading.
// Optional feature: define SEG_LZ_BLANK_EN for leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BRIGHT_W = 3
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  enable,
  output logic                  load_ack,
  output logic                  frame_done,
  output logic [DIGITS-1:0]     LEDSEL,
  output logic [7:0]            LEDOUT
);

  localparam int PHASES = 1 << BRIGHT_W;
  localparam int DIV    = CLK_HZ / (SCAN_HZ * PHASES);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_cnt_reg;
  logic [BRIGHT_W-1:0] phase_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                tick;
  logic                phase_wrap;
  logic                boundary;

  logic [4*DIGITS-1:0] act_val_reg;
  logic [DIGITS-1:0]   act_dp_reg;
  logic [4*DIGITS-1:0] pend_val_reg;
  logic [DIGITS-1:0]   pend_dp_reg;
  logic                pend_flag_reg;
  logic                load_ack_reg;
  logic                frame_done_reg;

  logic [3:0]          act_nib [DIGITS];
  logic [DIGITS-1:0]   lz_blank;
  logic [6:0]          dec_seg;
  logic                lit;
  logic [DIGITS-1:0]   ledsel_next;
  logic [7:0]          ledout_next;
  logic [DIGITS-1:0]   ledsel_reg;
  logic [7:0]          ledout_reg;

  assign tick       = (div_cnt_reg == DIV_LAST);
  assign phase_wrap = tick && (phase_reg == '1);
  assign boundary   = phase_wrap && (idx_reg == IDX_LAST);

  // Prescaler, PWM phase and digit index; all free-run regardless of enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      phase_reg   <= '0;
      idx_reg     <= '0;
    end else begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
      if (tick)
        phase_reg <= phase_reg + 1'b1;
      if (phase_wrap)
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  // Pending/active buffers: commit only on the frame boundary so a frame is never torn.
  // A load on the boundary cycle itself lands in pending and waits for the next boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_val_reg    <= '0;
      act_dp_reg     <= '0;
      pend_val_reg   <= '0;
      pend_dp_reg    <= '0;
      pend_flag_reg  <= 1'b0;
      load_ack_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (boundary && pend_flag_reg) begin
        act_val_reg <= pend_val_reg;
        act_dp_reg  <= pend_dp_reg;
      end
      if (load) begin
        pend_val_reg  <= value;
        pend_dp_reg   <= dp_mask;
        pend_flag_reg <= 1'b1;
      end else if (boundary) begin
        pend_flag_reg <= 1'b0;
      end
      load_ack_reg   <= boundary && pend_flag_reg;
      frame_done_reg <= boundary;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign act_nib[gi] = act_val_reg[4*gi +: 4];
    end
  endgenerate

`ifdef SEG_LZ_BLANK_EN
  // Digit k>0 goes dark when it and every digit to its left are zero with no dp.
  assign lz_blank[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign lz_blank[gi] = (act_val_reg[4*DIGITS-1:4*gi] == '0) && !act_dp_reg[gi];
    end
  endgenerate
`else
  assign lz_blank = '0;
`endif

  seg_hex_decode u_dec (
    .nibble (act_nib[idx_reg]),
    .seg    (dec_seg)
  );

  // Next select/segment pair derived from the current counter and buffer state.
  always_comb begin
    lit         = enable && (phase_reg <= bright);
    ledsel_next = '1;
    ledout_next = SEG_OFF;
    if (lit) begin
      ledsel_next = ~(DIGITS'(1) << idx_reg);
      if (!lz_blank[idx_reg])
        ledout_next = {~act_dp_reg[idx_reg], dec_seg};
    end
  end

  // Select and segments share one register stage so they always switch together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ledsel_reg <= '1;
      ledout_reg <= SEG_OFF;
    end else begin
      ledsel_reg <= ledsel_next;
      ledout_reg <= ledout_next;
    end
  end

  assign LEDSEL     = ledsel_reg;
  assign LEDOUT     = ledout_reg;
  assign load_ack   = load_ack_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised N-digit seven-segment scan driver for the FPGA top level. It replaces the fixed 4-digit mux and its external 5 kHz scan clock. It runs on the system clock with an internal prescaler, hex decode, per-digit decimal points, PWM brightness and tear-free double-buffered value loading. It sits between a GPO register and the board's LEDSEL/LEDOUT pins.

## Interface
- DIGITS, 4, number of digits (1..8)
- CLK_HZ, 100_000_000, input clock frequency
- SCAN_HZ, 1000, digit-slot rate (slots per second)
- BRIGHT_W, 3, brightness/PWM phase width; 2^BRIGHT_W phases per slot
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- value  in  4*DIGITS  hex nibbles; nibble k drives digit k (digit 0 rightmost)
- dp_mask  in  DIGITS  decimal point request per digit, 1 = lit
- load  in  1  single-cycle strobe; captures value/dp_mask into the pending buffer
- bright  in  BRIGHT_W  brightness level
- enable  in  1  0 = display dark, scan counters keep running
- load_ack  out  1  one-cycle pulse when the pending buffer is committed to display
- frame_done  out  1  one-cycle pulse when the digit index wraps DIGITS-1 -> 0
- LEDSEL  out  DIGITS  digit anodes, active-low
- LEDOUT  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

## Operation
- Sub-tick divider: DIV = CLK_HZ/(SCAN_HZ*2^BRIGHT_W); counter runs 0..DIV-1 and emits tick on DIV-1. Width is $clog2(DIV).
- Phase counter (BRIGHT_W bits) advances on tick. When the phase wraps, the digit index advances 0..DIGITS-1 and wraps to 0.
- Digit k is lit (LEDSEL[k]=0) only when index==k, phase <= bright, and enable=1. All other select bits are 1.
- bright=0 gives 1/2^BRIGHT_W duty; bright = all-ones gives full duty.
- Segment code comes from the active nibble via hex decode (0 -> 8'hC0, 5 -> 8'h92, A -> 8'h88, b -> 8'h83). dp bit = ~dp_mask[index]. While the digit is not lit, LEDOUT = 8'hFF.
- Double buffer:
  - load copies value/dp_mask to pending and sets the pending flag. A later load before commit overwrites (last wins).
  - At the frame boundary (index wrap), if the pending flag was set at the start of that cycle: active <= pending, flag clears, load_ack pulses.
  - A load coincident with the boundary cycle stays pending and commits at the next boundary.
- Reset:
  - LEDSEL all ones, LEDOUT 8'hFF, load_ack 0, frame_done 0.
  - Active and pending buffers cleared to 0, pending flag cleared.
  - All counters 0.
  - Reset asserted mid-frame drops any pending load.

## Timing
- LEDSEL/LEDOUT are registered, one clk after the counter state they reflect. Select and segments always change on the same edge (no ghosting).
- frame_done and load_ack assert in the same cycle as the boundary register update. They are never high for more than one cycle.
- Frame period = DIGITS * 2^BRIGHT_W * DIV clk cycles.
- First digit-0 slot begins on the first edge after rst deasserts.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero blanking.
  - Digit k with k>0 is blanked (LEDOUT=8'hFF, LEDSEL still follows PWM) when every active nibble at positions >= k is zero and dp_mask[k]=0.
  - Digit 0 is never blanked.
  - The blank mask is computed from the active buffer, so it changes only at commit.
- Undefined: every digit shows its nibble, including leading zeros.

## Structure
- Shared package seg_pkg: segment-code localparams for 0..F, SEG_OFF = 8'hFF, and bit positions of dp/g..a.
- One sub-module seg_hex_decode (4-bit nibble -> 7 active-low segments, combinational), instanced once on the muxed nibble.
- Prescaler, phase and index counters, buffers and output registers live in the top of this block.

## Test plan
All scenarios use DIGITS=4, CLK_HZ=32, SCAN_HZ=1, BRIGHT_W=2, giving DIV=8, slot=32 clk, frame=128 clk.
- Reset: rst=0 mid-run -> LEDSEL=4'b1111, LEDOUT=8'hFF immediately, load_ack=0. After release, digit 0 is selected one clk later.
- Load 16'h12AB, dp_mask=4'b0100, bright=3 -> load_ack pulses at the next wrap. Digit0 shows 8'h83, digit1 8'h88, digit2 8'h24 (2 with dp), digit3 8'hF9.
- bright=0, enable=1 -> each digit's LEDSEL bit is low for 8 of its 32 slot cycles. enable=0 -> LEDSEL stays 4'b1111 while frame_done keeps pulsing every 128 clk.
- Two loads (16'h1111, then 16'h2222) within one frame -> single load_ack. Display shows 2222; 1111 never appears.
- Load asserted exactly on the frame_done cycle -> no load_ack that frame; commit and ack occur 128 clk later.
- value=16'h0050, dp_mask=0:
  - with SEG_LZ_BLANK_EN: digits 3 and 2 show 8'hFF, digit1 shows 8'h92, digit0 shows 8'hC0.
  - without: digit3 shows 8'hC0.
